// File: rtl/qspi_tran_sequencer.sv
// QSPI transaction sequencer: INST/ADDR/DUMMY/DATA phases, SCK = clock/2, SPI mode 0.
// Optional build macro QSPI_TRAN_BYTE_SWAP_EN sends/assembles FIFO words byte0 first.
module qspi_tran_sequencer (
    input  logic        clock,
    input  logic        rst_n,
    input  logic        io_buf_req_valid,
    output logic        io_buf_req_ready,
    input  logic [7:0]  io_buf_req_inst,
    input  logic        io_buf_req_inst_label,
    input  logic [23:0] io_buf_req_addr,
    input  logic        io_buf_req_wr_en,
    input  logic        io_buf_req_rd_en,
    input  logic        io_buf_req_addr_en,
    input  logic        io_buf_req_erase_en,
    input  logic        io_buf_req_dummy_en,
    input  logic [7:0]  io_buf_req_data_burstlen,
    input  logic [7:0]  io_buf_req_dummy_burstlen,
    input  logic        io_buf_req_addr_spi_mode,
    input  logic        io_buf_req_addr_dpi_mode,
    input  logic        io_buf_req_data_spi_mode,
    input  logic        io_buf_req_data_dpi_mode,
    output logic        io_tran_inst_label,
    output logic        io_tran_spi_mode,
    output logic        io_tran_dpi_mode,
    output logic        io_tdata_lock,
    output logic        io_tdata_fifo_ren,
    input  logic [31:0] io_tdata_fifo_rdata,
    input  logic        io_tdata_fifo_empty,
    output logic        io_rdata_fifo_wen,
    output logic [31:0] io_rdata_fifo_wdata,
    input  logic        io_rdata_fifo_full,
    output logic        io_qspi_sck,
    output logic        io_qspi_cs_n,
    output logic [3:0]  io_qspi_dq_o,
    output logic [3:0]  io_qspi_dq_oe,
    input  logic [3:0]  io_qspi_dq_i
);

    typedef enum logic [2:0] {IDLE, INST, ADDR, DUMMY, DATA, HOLD, DESEL} state_t;

    state_t      state_q, state_d;
    logic        ready_q, ready_d;
    logic        sck_q, sck_d;
    logic        setup_q, setup_d;
    logic        gap_q, gap_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  words_q, words_d;
    logic [31:0] shreg_q, shreg_d;
    logic [31:0] rx_q, rx_d;
    logic [23:0] addr_q, addr_d;
    logic        addr_go_q, addr_go_d;
    logic        dummy_go_q, dummy_go_d;
    logic        data_go_q, data_go_d;
    logic        wr_q, wr_d;
    logic        label_q, label_d;
    logic [7:0]  dlen_q, dlen_d;
    logic [7:0]  blen_q, blen_d;
    logic [2:0]  al_q, al_d;
    logic [2:0]  dl_q, dl_d;

    logic [2:0]  cur_l;
    logic [31:0] sample;
    logic        phase_done;
    logic        drive_en;

    function automatic logic [2:0] lane_cnt(input logic spi, input logic dpi);
        if (spi)      return 3'd1;
        else if (dpi) return 3'd2;
        else          return 3'd4;
    endfunction

    function automatic logic [7:0] word_cycles(input logic [2:0] l);
        case (l)
            3'd1:    return 8'd32;
            3'd2:    return 8'd16;
            default: return 8'd8;
        endcase
    endfunction

    function automatic logic [7:0] addr_cycles(input logic [2:0] l);
        case (l)
            3'd1:    return 8'd24;
            3'd2:    return 8'd12;
            default: return 8'd6;
        endcase
    endfunction

    function automatic logic [31:0] wire_order(input logic [31:0] w);
`ifdef QSPI_TRAN_BYTE_SWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    always_comb begin
        case (state_q)
            ADDR:        cur_l = al_q;
            DUMMY, DATA: cur_l = dl_q;
            default:     cur_l = 3'd1;
        endcase
    end

    // Single-lane reads take MISO from dq[1], as a flash device drives it.
    always_comb begin
        case (dl_q)
            3'd1:    sample = {31'd0, io_qspi_dq_i[1]};
            3'd2:    sample = {30'd0, io_qspi_dq_i[1:0]};
            default: sample = {28'd0, io_qspi_dq_i};
        endcase
    end

    always_comb begin
        state_d    = state_q;
        sck_d      = sck_q;
        setup_d    = setup_q;
        gap_d      = gap_q;
        cnt_d      = cnt_q;
        words_d    = words_q;
        shreg_d    = shreg_q;
        rx_d       = rx_q;
        addr_d     = addr_q;
        addr_go_d  = addr_go_q;
        dummy_go_d = dummy_go_q;
        data_go_d  = data_go_q;
        wr_d       = wr_q;
        label_d    = label_q;
        dlen_d     = dlen_q;
        blen_d     = blen_q;
        al_d       = al_q;
        dl_d       = dl_q;
        phase_done = 1'b0;
        io_tdata_fifo_ren = 1'b0;
        io_rdata_fifo_wen = 1'b0;

        case (state_q)
            IDLE: begin
                if (io_buf_req_valid && ready_q) begin
                    state_d    = INST;
                    setup_d    = 1'b1;
                    sck_d      = 1'b0;
                    shreg_d    = {io_buf_req_inst, 24'd0};
                    cnt_d      = 8'd8;
                    addr_d     = io_buf_req_addr;
                    label_d    = io_buf_req_inst_label;
                    addr_go_d  = io_buf_req_addr_en;
                    dummy_go_d = io_buf_req_dummy_en && !io_buf_req_erase_en
                                 && (io_buf_req_dummy_burstlen != 8'd0);
                    data_go_d  = (io_buf_req_wr_en || io_buf_req_rd_en) && !io_buf_req_erase_en
                                 && (io_buf_req_data_burstlen != 8'd0);
                    wr_d       = io_buf_req_wr_en && !io_buf_req_erase_en
                                 && (io_buf_req_data_burstlen != 8'd0);
                    dlen_d     = io_buf_req_dummy_burstlen;
                    blen_d     = io_buf_req_data_burstlen;
                    al_d       = lane_cnt(io_buf_req_addr_spi_mode, io_buf_req_addr_dpi_mode);
                    dl_d       = lane_cnt(io_buf_req_data_spi_mode, io_buf_req_data_dpi_mode);
                end
            end
            INST, ADDR, DUMMY: begin
                // One extra low cycle after cs_n falls gives the flash its select setup time.
                if (setup_q) begin
                    setup_d = 1'b0;
                end else if (!sck_q) begin
                    sck_d = 1'b1;
                end else begin
                    sck_d   = 1'b0;
                    shreg_d = shreg_q << cur_l;
                    if (cnt_q == 8'd1) phase_done = 1'b1;
                    else               cnt_d = cnt_q - 8'd1;
                end
            end
            DATA: begin
                if (wr_q) begin
                    if (gap_q) begin
                        if (!io_tdata_fifo_empty) begin
                            io_tdata_fifo_ren = 1'b1;
                            shreg_d = wire_order(io_tdata_fifo_rdata);
                            gap_d   = 1'b0;
                            cnt_d   = word_cycles(dl_q);
                        end
                    end else if (!sck_q) begin
                        sck_d = 1'b1;
                    end else begin
                        sck_d   = 1'b0;
                        shreg_d = shreg_q << cur_l;
                        if (cnt_q == 8'd1) begin
                            words_d = words_q - 8'd1;
                            if (words_q == 8'd1) state_d = HOLD;
                            else                 gap_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q - 8'd1;
                        end
                    end
                end else begin
                    if (gap_q) begin
                        if (!io_rdata_fifo_full) begin
                            io_rdata_fifo_wen = 1'b1;
                            words_d = words_q - 8'd1;
                            if (words_q == 8'd1) begin
                                state_d = HOLD;
                            end else begin
                                gap_d = 1'b0;
                                cnt_d = word_cycles(dl_q);
                            end
                        end
                    end else if (!sck_q) begin
                        sck_d = 1'b1;
                        rx_d  = (rx_q << cur_l) | sample;
                    end else begin
                        sck_d = 1'b0;
                        if (cnt_q == 8'd1) gap_d = 1'b1;
                        else               cnt_d = cnt_q - 8'd1;
                    end
                end
            end
            HOLD: begin
                state_d = DESEL;
                cnt_d   = 8'd2;
            end
            DESEL: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd1) begin
                    state_d = IDLE;
                    label_d = 1'b0;
                    wr_d    = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (phase_done) begin
            if (state_q == INST && addr_go_q) begin
                state_d = ADDR;
                shreg_d = {addr_q, 8'd0};
                cnt_d   = addr_cycles(al_q);
            end else if (state_q != DUMMY && dummy_go_q) begin
                state_d = DUMMY;
                cnt_d   = dlen_q;
            end else if (data_go_q) begin
                state_d = DATA;
                words_d = blen_q;
                gap_d   = wr_q;
                cnt_d   = word_cycles(dl_q);
                rx_d    = '0;
            end else begin
                state_d = HOLD;
            end
        end

        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ready_q    <= 1'b0;
            sck_q      <= 1'b0;
            setup_q    <= 1'b0;
            gap_q      <= 1'b0;
            cnt_q      <= '0;
            words_q    <= '0;
            shreg_q    <= '0;
            rx_q       <= '0;
            addr_q     <= '0;
            addr_go_q  <= 1'b0;
            dummy_go_q <= 1'b0;
            data_go_q  <= 1'b0;
            wr_q       <= 1'b0;
            label_q    <= 1'b0;
            dlen_q     <= '0;
            blen_q     <= '0;
            al_q       <= 3'd1;
            dl_q       <= 3'd1;
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            sck_q      <= sck_d;
            setup_q    <= setup_d;
            gap_q      <= gap_d;
            cnt_q      <= cnt_d;
            words_q    <= words_d;
            shreg_q    <= shreg_d;
            rx_q       <= rx_d;
            addr_q     <= addr_d;
            addr_go_q  <= addr_go_d;
            dummy_go_q <= dummy_go_d;
            data_go_q  <= data_go_d;
            wr_q       <= wr_d;
            label_q    <= label_d;
            dlen_q     <= dlen_d;
            blen_q     <= blen_d;
            al_q       <= al_d;
            dl_q       <= dl_d;
        end
    end

    assign drive_en = (state_q == INST) || (state_q == ADDR) || (state_q == DATA && wr_q);

    always_comb begin
        io_qspi_dq_o  = '0;
        io_qspi_dq_oe = '0;
        if (drive_en) begin
            case (cur_l)
                3'd1:    io_qspi_dq_oe = 4'b0001;
                3'd2:    io_qspi_dq_oe = 4'b0011;
                default: io_qspi_dq_oe = 4'b1111;
            endcase
            if (!(state_q == DATA && gap_q)) begin
                case (cur_l)
                    3'd1:    io_qspi_dq_o = {3'd0, shreg_q[31]};
                    3'd2:    io_qspi_dq_o = {2'd0, shreg_q[31:30]};
                    default: io_qspi_dq_o = shreg_q[31:28];
                endcase
            end
        end
    end

    assign io_buf_req_ready    = ready_q;
    assign io_qspi_sck         = sck_q;
    assign io_qspi_cs_n        = (state_q == IDLE) || (state_q == DESEL);
    assign io_tran_spi_mode    = (cur_l == 3'd1);
    assign io_tran_dpi_mode    = (cur_l == 3'd2);
    assign io_tdata_lock       = wr_q;
    assign io_tran_inst_label  = label_q;
    assign io_rdata_fifo_wdata = wire_order(rx_q);

endmodule

// File: tb/tb_qspi_tran_sequencer.sv
// Randomized self-checking bench for qspi_tran_sequencer: wire-level model of the
// expected SCK-cycle stream, FIFO models and directed corner cases.
module tb_qspi_tran_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid, ready;
    logic [7:0]  inst;
    logic        label_in;
    logic [23:0] addr;
    logic        wr_en, rd_en, addr_en, erase_en, dummy_en;
    logic [7:0]  blen, dlen;
    logic        a_spi, a_dpi, d_spi, d_dpi;
    logic        label_out, spi_mode, dpi_mode, lock;
    logic        ren, empty, wen, full;
    logic [31:0] rdata, wdata;
    logic        sck, cs_n;
    logic [3:0]  dq_o, dq_oe, dq_i;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [7:0]  inst;
        logic        label;
        logic [23:0] addr;
        logic        wr, rd, ae, er, de;
        logic [7:0]  blen, dlen;
        logic        as, ad, ds, dd;
    } req_t;

    logic [31:0] data_w [4];
    logic [9:0]  exp_q[$];
    logic [3:0]  din_q[$];
    logic [31:0] txq[$];
    logic [31:0] rxw_q[$];

    always #5 clk = ~clk;

    qspi_tran_sequencer dut (
        .clock(clk), .rst_n(rst_n),
        .io_buf_req_valid(valid), .io_buf_req_ready(ready),
        .io_buf_req_inst(inst), .io_buf_req_inst_label(label_in), .io_buf_req_addr(addr),
        .io_buf_req_wr_en(wr_en), .io_buf_req_rd_en(rd_en), .io_buf_req_addr_en(addr_en),
        .io_buf_req_erase_en(erase_en), .io_buf_req_dummy_en(dummy_en),
        .io_buf_req_data_burstlen(blen), .io_buf_req_dummy_burstlen(dlen),
        .io_buf_req_addr_spi_mode(a_spi), .io_buf_req_addr_dpi_mode(a_dpi),
        .io_buf_req_data_spi_mode(d_spi), .io_buf_req_data_dpi_mode(d_dpi),
        .io_tran_inst_label(label_out), .io_tran_spi_mode(spi_mode), .io_tran_dpi_mode(dpi_mode),
        .io_tdata_lock(lock),
        .io_tdata_fifo_ren(ren), .io_tdata_fifo_rdata(rdata), .io_tdata_fifo_empty(empty),
        .io_rdata_fifo_wen(wen), .io_rdata_fifo_wdata(wdata), .io_rdata_fifo_full(full),
        .io_qspi_sck(sck), .io_qspi_cs_n(cs_n), .io_qspi_dq_o(dq_o), .io_qspi_dq_oe(dq_oe),
        .io_qspi_dq_i(dq_i)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int lanes_of(input logic spi, input logic dpi);
        return spi ? 1 : (dpi ? 2 : 4);
    endfunction

    // Order in which a FIFO word appears on the wire, first bit in [31].
    function automatic logic [31:0] wire_stream(input logic [31:0] w);
`ifdef QSPI_TRAN_BYTE_SWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    // One entry per SCK cycle: {spi,dpi,oe,dq_o} expected at the rise, dq_i to present.
    task automatic push_stream(input logic [31:0] s, input int nbits, input int lanes,
                               input bit is_read);
        logic [3:0] mask = (lanes == 1) ? 4'b0001 : (lanes == 2) ? 4'b0011 : 4'b1111;
        logic [1:0] md   = {lanes == 1, lanes == 2};
        for (int k = 0; k < nbits / lanes; k++) begin
            logic [3:0] v = '0;
            logic [3:0] rn = 4'($urandom);
            for (int n = 0; n < lanes; n++) v[n] = s[31 - (k * lanes + lanes - 1 - n)];
            if (!is_read) begin
                exp_q.push_back({md, mask, v});
                din_q.push_back(rn);
            end else begin
                exp_q.push_back({md, 8'h00});
                if (lanes == 1)      din_q.push_back({rn[3:2], v[0], rn[0]});
                else if (lanes == 2) din_q.push_back({rn[3:2], v[1:0]});
                else                 din_q.push_back(v);
            end
        end
    endtask

    // kind: 0 random FIFO stalls, 1 empty window at data start, 2 full window
    // after first read word, 3 reset in the middle of the data phase.
    task automatic run_txn(input req_t r, input int kind, input int exp_low);
        int al = lanes_of(r.as, r.ad);
        int dl = lanes_of(r.ds, r.dd);
        bit datago = (r.wr || r.rd) && !r.er && (r.blen != 0);
        bit wp = datago && r.wr;
        bit lock_known = wp || !r.wr;
        int pre, wc, n_rise, low, desel, cyc, win;
        bit prev_sck, seen_low, done, wchk, fe, ff;

        exp_q.delete(); din_q.delete(); txq.delete(); rxw_q.delete();
        push_stream({r.inst, 24'd0}, 8, 1, 0);
        if (r.ae) push_stream({r.addr, 8'd0}, 24, al, 0);
        if (r.de && !r.er && r.dlen != 0)
            for (int k = 0; k < r.dlen; k++) begin
                exp_q.push_back({dl == 1, dl == 2, 8'h00});
                din_q.push_back(4'($urandom));
            end
        pre = exp_q.size();
        wc = 32 / dl;
        if (datago)
            for (int w = 0; w < r.blen; w++) begin
                if (wp) txq.push_back(data_w[w]);
                else    rxw_q.push_back(data_w[w]);
                push_stream(wire_stream(data_w[w]), 32, dl, !wp);
            end

        @(negedge clk);
        inst = r.inst; label_in = r.label; addr = r.addr;
        wr_en = r.wr; rd_en = r.rd; addr_en = r.ae; erase_en = r.er; dummy_en = r.de;
        blen = r.blen; dlen = r.dlen; a_spi = r.as; a_dpi = r.ad; d_spi = r.ds; d_dpi = r.dd;
        valid = 1'b1;
        #1 check_val("ready_idle", ready, 1);

        n_rise = 0; low = 0; desel = 0; cyc = 0; win = 0;
        prev_sck = 0; seen_low = 0; done = 0; wchk = 0;
        while (!done && cyc < 4000) begin
            @(negedge clk);
            valid = 1'b0;
            cyc++;
            fe = (kind == 0) && ($urandom_range(0, 3) == 0);
            ff = (kind == 0) && ($urandom_range(0, 3) == 0);
            if (kind == 1 && n_rise == pre && win < 10) begin fe = 1; win++; end
            if (kind == 2 && n_rise == pre + wc && win < 6) begin ff = 1; win++; end
            empty = (txq.size() == 0) || fe;
            rdata = (txq.size() != 0) ? txq[0] : 32'($urandom);
            full  = ff;
            dq_i  = (n_rise < din_q.size()) ? din_q[n_rise] : 4'($urandom);
            #1;
            if (!cs_n) begin
                low++; seen_low = 1;
                check_val("label", label_out, r.label);
                check_val("ready_busy", ready, 0);
                if (lock_known) check_val("lock", lock, wp);
            end else begin
                check_val("sck_idle", sck, 0);
                if (seen_low && !ready) begin
                    desel++;
                    if (lock_known) check_val("lock_desel", lock, wp);
                end
            end
            if (sck && !prev_sck) begin
                if (n_rise < exp_q.size())
                    check_val("rise_bits", {22'd0, spi_mode, dpi_mode, dq_oe, dq_o}, {22'd0, exp_q[n_rise]});
                else
                    check_val("rise_extra", n_rise, exp_q.size());
                n_rise++;
            end
            prev_sck = sck;
            if (ren) begin
                check_val("ren_empty", empty, 0);
                if (txq.size() != 0) void'(txq.pop_front());
            end
            if (wen) begin
                check_val("wen_full", full, 0);
                if (rxw_q.size() != 0) check_val("rd_word", wdata, rxw_q.pop_front());
                else                   check_val("wen_extra", 1, 0);
            end
            if ((kind == 1 && win == 10 || kind == 2 && win == 6) && !wchk) begin
                wchk = 1;
                check_val("pause_sck", sck, 0);
                check_val("pause_rises", n_rise, (kind == 1) ? pre : pre + wc);
            end
            if (kind == 3 && n_rise == pre + 5) begin
                rst_n = 1'b0;
                @(negedge clk); #1;
                check_val("rst_cs_n", cs_n, 1);
                check_val("rst_sck", sck, 0);
                check_val("rst_oe", dq_oe, 0);
                check_val("rst_dq", dq_o, 0);
                check_val("rst_fifo", {ren, wen}, 0);
                check_val("rst_lock_lbl", {lock, label_out}, 0);
                check_val("rst_modes", {spi_mode, dpi_mode}, 2'b10);
                check_val("rst_ready", ready, 0);
                rst_n = 1'b1;
                @(negedge clk); #1;
                check_val("rst_release_ready", ready, 1);
                txq.delete(); rxw_q.delete();
                return;
            end
            if (seen_low && ready) done = 1;
        end
        check_val("timeout", done, 1);
        check_val("rises", n_rise, exp_q.size());
        check_val("rd_left", rxw_q.size(), 0);
        check_val("tx_left", txq.size(), 0);
        check_val("desel_cycles", desel, 2);
        if (exp_low != 0) check_val("cs_low", low, exp_low);
        empty = 1'b1; full = 1'b0;
    endtask

    initial begin
        req_t r;
        rst_n = 1'b0; valid = 0; inst = '0; label_in = 0; addr = '0;
        wr_en = 0; rd_en = 0; addr_en = 0; erase_en = 0; dummy_en = 0;
        blen = '0; dlen = '0; a_spi = 0; a_dpi = 0; d_spi = 0; d_dpi = 0;
        rdata = '0; empty = 1; full = 0; dq_i = '0;
        repeat (3) @(negedge clk);
        #1;
        check_val("init_ready", ready, 0);
        check_val("init_cs_sck", {cs_n, sck}, 2'b10);
        check_val("init_dq", {dq_oe, dq_o}, 0);
        check_val("init_modes", {spi_mode, dpi_mode, lock, label_out, ren, wen}, 6'b100000);
        rst_n = 1'b1;
        @(negedge clk); #1;
        check_val("init_release_ready", ready, 1);

        // Write-enable style command: instruction only.
        r = '{inst:8'h06, label:1'b0, addr:24'h0, wr:0, rd:0, ae:0, er:0, de:0,
              blen:8'd0, dlen:8'd0, as:0, ad:0, ds:0, dd:0};
        run_txn(r, 0, 18);

        // Quad fast read with address, 4 dummy cycles, two words.
        data_w[0] = 32'hA5A5A5A5; data_w[1] = 32'h0F0F0F0F;
        r = '{inst:8'hEB, label:1'b1, addr:24'h123456, wr:0, rd:1, ae:1, er:0, de:1,
              blen:8'd2, dlen:8'd4, as:0, ad:0, ds:0, dd:0};
        run_txn(r, 0, 0);

        // Single-lane write with the transmit FIFO held empty at data start.
        data_w[0] = 32'hDEADBEEF;
        r = '{inst:8'h02, label:1'b1, addr:24'hABCDEF, wr:1, rd:0, ae:1, er:0, de:0,
              blen:8'd1, dlen:8'd0, as:1, ad:0, ds:1, dd:0};
        run_txn(r, 1, 0);

        // Dual read, receive FIFO full once the first word is assembled.
        data_w[0] = 32'h01234567; data_w[1] = 32'h89ABCDEF; data_w[2] = 32'hCAFEF00D;
        r = '{inst:8'h3B, label:1'b0, addr:24'h000100, wr:0, rd:1, ae:1, er:0, de:1,
              blen:8'd3, dlen:8'd2, as:1, ad:1, ds:0, dd:1};
        run_txn(r, 2, 0);

        // Byte-order probe word.
        data_w[0] = 32'h11223344;
        r = '{inst:8'h02, label:1'b0, addr:24'h000000, wr:1, rd:1, ae:0, er:0, de:0,
              blen:8'd1, dlen:8'd0, as:1, ad:0, ds:1, dd:0};
        run_txn(r, 0, 0);

        // Erase without address: instruction only even with dummy/data enables.
        r = '{inst:8'hC7, label:1'b1, addr:24'h0, wr:1, rd:0, ae:0, er:1, de:1,
              blen:8'd2, dlen:8'd3, as:0, ad:0, ds:0, dd:0};
        run_txn(r, 0, 18);

        // Reset asserted during a quad read data phase.
        data_w[0] = 32'h55AA55AA; data_w[1] = 32'h12345678; data_w[2] = 32'h9ABCDEF0;
        r = '{inst:8'h6B, label:1'b1, addr:24'h00FF00, wr:0, rd:1, ae:1, er:0, de:0,
              blen:8'd3, dlen:8'd0, as:1, ad:0, ds:0, dd:0};
        run_txn(r, 3, 0);

        for (int t = 0; t < 40; t++) begin
            for (int w = 0; w < 4; w++) data_w[w] = $urandom;
            r.inst = 8'($urandom); r.label = 1'($urandom); r.addr = 24'($urandom);
            r.wr = 1'($urandom); r.rd = 1'($urandom); r.ae = 1'($urandom);
            r.er = ($urandom_range(0, 7) == 0); r.de = 1'($urandom);
            r.blen = 8'($urandom_range(0, 4)); r.dlen = 8'($urandom_range(0, 5));
            r.as = 1'($urandom); r.ad = 1'($urandom); r.ds = 1'($urandom); r.dd = 1'($urandom);
            run_txn(r, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/qspi_tran_sequencer.md
QSPI_TRAN_SEQUENCER -- requirements
Module: qspi_tran_sequencer

Interface
REQ-001 SHALL have ports: clock  in  1  sole clock; rst_n  in  1  reset, synchronous, active-low.
REQ-002 SHALL have ports: io_buf_req_valid  in  1; io_buf_req_ready  out  1  request handshake from the control level.
REQ-003 SHALL have ports: io_buf_req_inst  in  8  opcode; io_buf_req_inst_label  in  1  0=cchan, 1=dchan; io_buf_req_addr  in  24.
REQ-004 SHALL have ports: io_buf_req_wr_en, io_buf_req_rd_en, io_buf_req_addr_en, io_buf_req_erase_en, io_buf_req_dummy_en  in  1 each  phase enables.
REQ-005 SHALL have ports: io_buf_req_data_burstlen  in  8  32-bit data words; io_buf_req_dummy_burstlen  in  8  dummy SCK cycles.
REQ-006 SHALL have ports: io_buf_req_addr_spi_mode, io_buf_req_addr_dpi_mode, io_buf_req_data_spi_mode, io_buf_req_data_dpi_mode  in  1 each  lane select, spi=1 lane, dpi=2 lanes, neither=4 lanes, spi wins if both set.
REQ-007 SHALL have ports: io_tran_inst_label  out  1  label of active request; io_tran_spi_mode, io_tran_dpi_mode  out  1  lane mode of current phase; io_tdata_lock  out  1  write-data phase active.
REQ-008 SHALL have ports: io_tdata_fifo_ren  out  1; io_tdata_fifo_rdata  in  32; io_tdata_fifo_empty  in  1  transmit FIFO read side, data valid same cycle as ren.
REQ-009 SHALL have ports: io_rdata_fifo_wen  out  1; io_rdata_fifo_wdata  out  32; io_rdata_fifo_full  in  1  receive FIFO write side.
REQ-010 SHALL have ports: io_qspi_sck  out  1; io_qspi_cs_n  out  1; io_qspi_dq_o  out  4; io_qspi_dq_oe  out  4; io_qspi_dq_i  in  4.

Function
REQ-011 SHALL implement FSM states IDLE, INST, ADDR, DUMMY, DATA, HOLD, DESEL.
REQ-012 SHALL assert io_buf_req_ready only in IDLE; valid&ready latches all request fields and moves to INST with cs_n low next cycle.
REQ-013 SHALL run SCK at clock/2, SPI mode 0: SCK idles low; dq_o updates on the clock where SCK falls (or phase start); dq_i sampled on the clock where SCK rises.
REQ-014 SHALL send INST as 8 SCK cycles on dq[0], MSB first, dq_oe=4'b0001.
REQ-015 SHALL send ADDR only if addr_en: 24 bits MSB first, 24/12/6 SCK cycles for 1/2/4 lanes; lane n carries bit (k*lanes+lanes-1-n) order, highest bit on highest lane.
REQ-016 SHALL run DUMMY only if dummy_en and dummy_burstlen!=0: dummy_burstlen SCK cycles, dq_oe=0.
REQ-017 SHALL run DATA only if (wr_en or rd_en) and !erase_en and burstlen!=0; wr_en has priority over rd_en; 32/16/8 SCK cycles per word.
REQ-018 Write: SHALL pulse io_tdata_fifo_ren one cycle before each word's first bit; if io_tdata_fifo_empty, SHALL hold SCK low and cs_n low (pause) until non-empty.
REQ-019 Read: dq_oe=0; after a word's last sample SHALL pulse io_rdata_fifo_wen with the word; if io_rdata_fifo_full, SHALL pause SCK low before pulsing wen and resume when not full; no word is ever dropped.
REQ-020 SHALL go HOLD (1 cycle, SCK low) then DESEL with cs_n high for 2 cycles, then IDLE.
REQ-021 io_tdata_lock SHALL be 1 from INST entry to DESEL exit of a write request, else 0.
REQ-022 io_tran_inst_label SHALL hold the latched label from acceptance until IDLE re-entry.
REQ-023 Phase-skip rules: skipped phases take zero cycles; erase_en with addr_en=0 yields INST only.

Reset
REQ-024 On rst_n low at a clock edge, regardless of state, SHALL give: ready=0 during reset, cs_n=1, sck=0, dq_o=0, dq_oe=0, fifo ren/wen=0, lock=0, label=0, spi_mode=1, dpi_mode=0, FSM=IDLE; ready=1 first cycle after release.

Configuration
REQ-025 Macro QSPI_TRAN_BYTE_SWAP_EN: defined -> each 32-bit FIFO word transmitted/assembled byte0 ([7:0]) first, each byte MSB first; undefined -> bit31 first. ADDR/INST unaffected.

Verification
REQ-026 inst=0x06, all enables 0 -> 8 SCK cycles, dq_o[0] = 0,0,0,0,0,1,1,0, cs_n low 18 clocks then high 2, ready returns.
REQ-027 inst=0xEB, addr=0x123456 quad, dummy 4, rd_en, burstlen 2, dq_i feeds 0xA5A5A5A5/0x0F0F0F0F -> two wen pulses with those words, 8+6+4+16 SCK cycles.
REQ-028 wr_en single-lane, burstlen 1, FIFO empty 10 cycles then 0xDEADBEEF -> SCK frozen low during empty, then 32 bits 0xDEADBEEF MSB first, lock=1 throughout.
REQ-029 rd_en dual-lane, burstlen 3, rdata_full high after word 1 for 6 cycles -> SCK paused, 3 words delivered intact.
REQ-030 rst_n low mid-DATA -> next edge cs_n=1, sck=0, oe=0, ready=1 after release; with QSPI_TRAN_BYTE_SWAP_EN, write 0x11223344 -> wire order 0x44,0x33,0x22,0x11.
